// File: rtl/token_pkg.sv
// Shared constants and types for the token window counter slice.
// Defaults here feed the module parameters so the whole slice agrees on widths.
package token_pkg;

  // Enabled cycles that make up one counting window.
  localparam int DEF_WINDOW     = 16;
  // One window count must hold 0..WINDOW inclusive, hence WINDOW+1 values.
  localparam int DEF_CNT_W      = $clog2(DEF_WINDOW + 1);
  // Entries in the count FIFO; must be a power of two so pointers wrap cleanly.
  localparam int DEF_FIFO_DEPTH = 4;
  // Width of the saturating dropped-window counter.
  localparam int DEF_DROP_W     = 8;

  typedef logic [DEF_CNT_W-1:0]  tok_cnt_t;
  typedef logic [DEF_DROP_W-1:0] drop_cnt_t;

endpackage

// File: rtl/token_fifo.sv
// Small synchronous FIFO holding completed window counts.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// A push while full is accepted only when a pop frees the head slot on the same edge.
module token_fifo
  import token_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with different wrap bits means the writer has lapped the reader.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Popping an empty FIFO is ignored; a full FIFO accepts a push only alongside a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero while empty so the output is clean out of reset.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Advance each pointer by one on an accepted operation; wrap is natural.
  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; a full+pop push overwrites the slot being popped on this same edge.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/token_window_counter.sv
// Counts '1' tokens over windows of WINDOW enabled cycles from the halving stage.
// Each finished window's count is queued in token_fifo and offered on a valid/ready port.
// A window that finds the FIFO full (with no pop that cycle) is discarded; this is
// flagged by a one-cycle drop pulse and tallied in a saturating drop counter.
module token_window_counter
  import token_pkg::*;
#(
  parameter int WINDOW     = DEF_WINDOW,
  parameter int CNT_W      = $clog2(WINDOW + 1),
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DROP_W     = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              tok,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              cnt_valid,
  input  logic              cnt_ready,
  output logic              drop,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int                 PHASE_W    = $clog2(WINDOW);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(WINDOW - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               drop_q, drop_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic               win_end;
  logic [CNT_W-1:0]   push_data;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_head;

  // The last enabled cycle of a window closes it; its own token is folded into the count.
  assign win_end   = en & (phase_q == LAST_PHASE);
  assign push_data = acc_q + CNT_W'(tok);

  // Consumer handshake; the FIFO itself ignores pops while empty.
  assign pop = cnt_valid & cnt_ready;

  // Phase and accumulator advance only on enabled cycles and restart after a window end.
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    if (en) begin
      if (win_end) begin
        phase_d = '0;
        acc_d   = '0;
      end else begin
        phase_d = phase_q + 1'b1;
        acc_d   = acc_q + CNT_W'(tok);
      end
    end
  end

  // A window is lost only when the FIFO is full and nothing leaves it on the same edge.
  always_comb begin
    drop_d     = win_end & fifo_full & ~pop;
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  // Window counters and drop bookkeeping, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      acc_q      <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  token_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (win_end),
    .data_i  (push_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output port is the FIFO head; valid is simply non-empty, so it is fully registered.
  assign cnt_valid = ~fifo_empty;
  assign cnt_data  = fifo_head;
  assign drop      = drop_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_token_window_counter.sv
// Self-checking bench for token_window_counter with default parameters.
// A queue-based reference model tracks window counts, FIFO contents and drops.
module tb_token_window_counter;
  import token_pkg::*;

  localparam int WINDOW     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int DROP_MAX   = 255;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      en = 1'b0;
  logic      tok = 1'b0;
  logic      cnt_ready = 1'b0;
  tok_cnt_t  cnt_data;
  logic      cnt_valid;
  logic      drop;
  drop_cnt_t drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int model_q[$];
  int win_n = 0;
  int win_ones = 0;
  int exp_drop = 0;
  int exp_drop_cnt = 0;

  always #5 clk = ~clk;

  token_window_counter #(
    .WINDOW     (WINDOW),
    .CNT_W      (5),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DROP_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .tok       (tok),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .drop      (drop),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic step(input bit r, input bit e, input bit t, input bit rdy);
    bit pop_m, push_m, full_m;
    int val;
    rst = r; en = e; tok = t; cnt_ready = rdy;
    if (r) begin
      model_q.delete();
      win_n = 0; win_ones = 0; exp_drop = 0; exp_drop_cnt = 0;
    end else begin
      pop_m  = (model_q.size() > 0) && rdy;
      full_m = (model_q.size() == FIFO_DEPTH);
      push_m = e && (win_n == WINDOW - 1);
      val    = win_ones + int'(t);
      exp_drop = 0;
      if (e) begin
        if (push_m) begin
          win_n = 0; win_ones = 0;
        end else begin
          win_n++; win_ones += int'(t);
        end
      end
      if (pop_m) void'(model_q.pop_front());
      if (push_m) begin
        if (full_m && !pop_m) begin
          exp_drop = 1;
          if (exp_drop_cnt < DROP_MAX) exp_drop_cnt++;
        end else begin
          model_q.push_back(val);
        end
      end
    end
    @(posedge clk);
    #1;
    check("cnt_valid", int'(cnt_valid), (model_q.size() > 0) ? 1 : 0);
    check("cnt_data", int'(cnt_data), (model_q.size() > 0) ? model_q[0] : 0);
    check("drop", int'(drop), exp_drop);
    check("drop_cnt", int'(drop_cnt), exp_drop_cnt);
  endtask

  // A full window of enabled cycles, tokens taken MSB first from pat.
  task automatic run_pattern(input logic [WINDOW-1:0] pat, input bit rdy);
    for (int i = WINDOW - 1; i >= 0; i--) step(1'b0, 1'b1, pat[i], rdy);
  endtask

  // A full window with exactly k leading tokens; ready only on the last cycle if asked.
  task automatic run_ones(input int k, input bit rdy_last);
    for (int i = 0; i < WINDOW; i++)
      step(1'b0, 1'b1, (i < k), (i == WINDOW - 1) ? rdy_last : 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", int'(cnt_valid), 0);
    check("reset_data", int'(cnt_data), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);

    // 1. Alternating tokens, consumer always ready
    run_pattern(16'b1010_1010_1010_1010, 1'b1);
    check("t1_valid", int'(cnt_valid), 1);
    check("t1_count", int'(cnt_data), 8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_one_cycle", int'(cnt_valid), 0);

    // 2. Boundary counts: all ones then all zeros
    run_pattern(16'hFFFF, 1'b0);
    check("t2_all_ones", int'(cnt_data), 16);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run_pattern(16'h0000, 1'b0);
    check("t2_all_zeros_valid", int'(cnt_valid), 1);
    check("t2_all_zeros", int'(cnt_data), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 3. Enable gaps: 16 enabled cycles spread over 32 clocks
    for (int i = 0; i < 2 * WINDOW; i++) begin
      step(1'b0, (i % 2 == 0), 1'b1, 1'b0);
      if (i < 2 * WINDOW - 2) check("t3_no_early_push", int'(cnt_valid), 0);
    end
    check("t3_count", int'(cnt_data), 16);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("t3_single_count", int'(cnt_valid), 0);

    // 4. Backpressure and drops
    for (int w = 1; w <= 6; w++) begin
      run_ones(w, 1'b0);
      if (w >= 5) check("t4_drop_pulse", int'(drop), 1);
    end
    check("t4_drop_cnt", int'(drop_cnt), 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_drop_one_cycle", int'(drop), 0);
    for (int k = 1; k <= 4; k++) begin
      check("t4_pop_order", int'(cnt_data), k);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("t4_drained", int'(cnt_valid), 0);

    // 5. Full FIFO, ready only on the window-end cycle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 1; w <= 4; w++) run_ones(w, 1'b0);
    run_ones(5, 1'b1);
    check("t5_no_drop", int'(drop), 0);
    check("t5_head_advanced", int'(cnt_data), 2);
    check("t5_drop_cnt", int'(drop_cnt), 0);
    for (int k = 2; k <= 5; k++) begin
      check("t5_order_tail", int'(cnt_data), k);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end

    // 6. Mid-window reset with two counts queued
    run_ones(3, 1'b0);
    run_ones(16, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_valid_cleared", int'(cnt_valid), 0);
    check("t6_drop_cnt_cleared", int'(drop_cnt), 0);
    run_pattern(16'b0000_0000_0001_0111, 1'b0);
    check("t6_post_reset_count", int'(cnt_data), 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Drop counter saturation: 4 queued windows then 260 dropped ones
    for (int w = 0; w < FIFO_DEPTH + 260; w++) run_ones(w % 17, 1'b0);
    check("sat_drop_cnt", int'(drop_cnt), DROP_MAX);
    check("sat_head_kept", int'(cnt_data), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 9) < 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
